tl_cache_skid_latch: RTL

TL_CACHE_SKID_LATCH -- requirements
Module: tl_cache_skid_latch

---
 rtl/tl_cache_skid_latch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tl_cache_skid_latch.sv
// tl_cache_skid_latch
// Two-entry skid latch between the TL stage and the cache stage.
// The main register drives the cache side; the skid register absorbs one
// extra payload when the cache side is blocked, so tl_ready_o is decoded
// from the state register alone and never depends on c_ready_i or
// stall_core_i.
// A saturating counter records every cycle in which a valid output is blocked.

module tl_cache_skid_latch #(
    parameter int DATA_W = 124,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              kill_i,
    input  logic              stall_core_i,
    input  logic              tl_valid_i,
    output logic              tl_ready_o,
    input  logic [DATA_W-1:0] tl_data_i,
    output logic              c_valid_o,
    input  logic              c_ready_i,
    output logic [DATA_W-1:0] c_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // EMPTY: nothing held.
    // HALF: main holds the oldest payload.
    // FULL: main is the oldest payload and skid is the newest.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  main_d;
    logic [DATA_W-1:0]  skid_q;
    logic [DATA_W-1:0]  skid_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               xfer_in;
    logic               xfer_out;
    logic               out_blocked;
    logic               cnt_sat;

    // Handshake outputs and occupancy, decoded purely from the state register.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        tl_ready_o  = 1'b1;
        c_valid_o   = 1'b0;
        occupancy_o = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                tl_ready_o  = 1'b1;
                c_valid_o   = 1'b0;
                occupancy_o = 2'd0;
            end
            ST_HALF: begin
                tl_ready_o  = 1'b1;
                c_valid_o   = 1'b1;
                occupancy_o = 2'd1;
            end
            ST_FULL: begin
                tl_ready_o  = 1'b0;
                c_valid_o   = 1'b1;
                occupancy_o = 2'd2;
            end
            default: begin
                tl_ready_o  = 1'b1;
                c_valid_o   = 1'b0;
                occupancy_o = 2'd0;
            end
        endcase
    end

    assign c_data_o    = main_q;
    assign stall_cnt_o = cnt_q;

    // A transfer-out needs the core to be running as well as the cache ready.
    assign xfer_in     = tl_valid_i && tl_ready_o;
    assign xfer_out    = c_valid_o && c_ready_i && !stall_core_i;
    assign out_blocked = c_valid_o && (!c_ready_i || stall_core_i);
    assign cnt_sat     = &cnt_q;

    // Next-state and data-register update; kill overrides every other input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (kill_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_HALF;
                        main_d  = tl_data_i;
                    end
                end
                ST_HALF: begin
                    if (xfer_in && xfer_out) begin
                        // Old payload leaves while the new one takes its place.
                        state_d = ST_HALF;
                        main_d  = tl_data_i;
                    end else if (xfer_in) begin
                        // Output blocked: park the newcomer behind main.
                        state_d = ST_FULL;
                        skid_d  = tl_data_i;
                    end else if (xfer_out) begin
                        // main keeps its stale value; c_valid_o masks it.
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rsn_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        // NOTE: the payload registers are reset because c_data_o must read 0 while in reset.
        if (!rsn_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Saturating count of cycles with a valid but blocked output; kill does not clear it.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            cnt_q <= '0;
        end else if (out_blocked && !cnt_sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
